// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared types for the UART command sequencer: FSM state encoding and command opcodes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_cmd_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_WR_EXEC = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_EXEC = 3'd5,
      ST_RD_WAIT = 3'd6,
      ST_TX_SEND = 3'd7
   } state_t;

   localparam logic [7:0] CMD_WR_OP = 8'hAA;
   localparam logic [7:0] CMD_RD_OP = 8'hBB;

   // States in which the inter-byte timeout counter runs.
   function automatic logic st_timed(input state_t s);
      return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
             (s == ST_RD_WAIT) || (s == ST_TX_SEND);
   endfunction

   // States in which a line error kills the frame in progress.
   function automatic logic st_abortable(input state_t s);
      return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
             (s == ST_RD_WAIT);
   endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its UART RX/TX and register-file neighbours.
// Latency: n/a (wires only). Backpressure: tx_busy stalls the read response.
// Ports: master = sequencer side (drives rf_*, tx_p_data/tx_d_vld, frame_err, ctrl_busy); slave = environment.
interface uart_rx_cmd_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] rx_p_data;
   logic                  rx_d_vld;
   logic                  rx_par_err;
   logic                  rx_stp_err;
   logic                  rf_wr_en;
   logic                  rf_rd_en;
   logic [ADDR_WIDTH-1:0] rf_addr;
   logic [DATA_WIDTH-1:0] rf_wr_data;
   logic [DATA_WIDTH-1:0] rf_rd_data;
   logic                  rf_rd_data_vld;
   logic [DATA_WIDTH-1:0] tx_p_data;
   logic                  tx_d_vld;
   logic                  tx_busy;
   logic                  frame_err;
   logic                  ctrl_busy;

   modport master (
      input  rx_p_data, rx_d_vld, rx_par_err, rx_stp_err, rf_rd_data, rf_rd_data_vld, tx_busy,
      output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_p_data, tx_d_vld, frame_err, ctrl_busy
   );

   modport slave (
      output rx_p_data, rx_d_vld, rx_par_err, rx_stp_err, rf_rd_data, rf_rd_data_vld, tx_busy,
      input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, tx_p_data, tx_d_vld, frame_err, ctrl_busy
   );
endinterface

// File: rtl/uart_rx_cmd_ctrl_timer.sv
// Saturating inter-byte timeout counter; o_expire is combinational on the count reaching TIMEOUT_CYCLES-1.
// Latency: count updates one cycle after i_en; clear takes effect on the next edge.
// Backpressure: none. Ports: i_clk, i_rst (async active-low), i_clr, i_en, o_expire.
module uart_frame_timer #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [15:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= 16'd0;
      end else if (i_clr) begin
         r_cnt <= 16'd0;
      end else if (i_en && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // A zero limit disables the timeout entirely.
   assign o_expire = (TIMEOUT_CYCLES != 16'd0) && i_en && (r_cnt == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses received UART bytes into register-file write/read frames and returns read data to the transmitter.
// Latency: all outputs registered; strobes one cycle after their state is entered.
// Backpressure: read response waits in TX_SEND while tx_busy is high (bounded by the frame timeout).
// Ports: i_clk, i_rst (async active-low), bus (uart_rx_cmd_ctrl_if.master).
module uart_rx_cmd_ctrl
   import uart_rx_cmd_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    ADDR_WIDTH     = 4,
   parameter logic [15:0]           TIMEOUT_CYCLES = 16'd4096,
   parameter logic [DATA_WIDTH-1:0] CMD_WR         = DATA_WIDTH'(CMD_WR_OP),
   parameter logic [DATA_WIDTH-1:0] CMD_RD         = DATA_WIDTH'(CMD_RD_OP)
) (
   input logic                i_clk,
   input logic                i_rst,
   uart_rx_cmd_ctrl_if.master bus
);

   state_t                r_state;
   state_t                w_state_nxt;

   logic                  r_err_q;
   logic                  w_err_lvl;
   logic                  w_err_evt;
   logic                  w_accept;
   logic                  w_tmo;
   logic                  w_tmr_en;
   logic                  w_tmr_clr;

   logic [ADDR_WIDTH-1:0] r_rf_addr;
   logic [DATA_WIDTH-1:0] r_rf_wr_data;
   logic [DATA_WIDTH-1:0] r_tx_p_data;
   logic                  r_rf_wr_en;
   logic                  r_rf_rd_en;
   logic                  r_tx_d_vld;
   logic                  r_frame_err;
   logic                  r_ctrl_busy;

   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [DATA_WIDTH-1:0] w_wr_data_nxt;
   logic [DATA_WIDTH-1:0] w_tx_data_nxt;
   logic                  w_wr_en_nxt;
   logic                  w_rd_en_nxt;
   logic                  w_tx_vld_nxt;
   logic                  w_frame_err_nxt;

   assign w_accept  = bus.rx_d_vld;
   assign w_err_lvl = bus.rx_par_err | bus.rx_stp_err;
   // Only the rising edge counts, so a flag held high by the receiver aborts once.
   assign w_err_evt = w_err_lvl & ~r_err_q;

   // Counter restarts on every state change and on every received byte, even a dropped one.
   assign w_tmr_en  = st_timed(r_state);
   assign w_tmr_clr = (w_state_nxt != r_state) | w_accept;

   uart_frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (w_tmr_clr),
      .i_en     (w_tmr_en),
      .o_expire (w_tmo)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_rf_addr;
      w_wr_data_nxt   = r_rf_wr_data;
      w_tx_data_nxt   = r_tx_p_data;
      w_wr_en_nxt     = 1'b0;
      w_rd_en_nxt     = 1'b0;
      w_tx_vld_nxt    = 1'b0;
      w_frame_err_nxt = 1'b0;

      // A line error beats a byte accepted on the same cycle; that byte is discarded.
      if (st_abortable(r_state) && w_err_evt) begin
         w_state_nxt     = ST_IDLE;
         w_frame_err_nxt = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (bus.rx_p_data == CMD_WR) begin
                     w_state_nxt = ST_WR_ADDR;
                  end else if (bus.rx_p_data == CMD_RD) begin
                     w_state_nxt = ST_RD_ADDR;
                  end else begin
                     w_frame_err_nxt = 1'b1;
                  end
               end
            end
            ST_WR_ADDR: begin
               if (w_tmo) begin
                  w_state_nxt     = ST_IDLE;
                  w_frame_err_nxt = 1'b1;
               end else if (w_accept) begin
                  w_addr_nxt  = bus.rx_p_data[ADDR_WIDTH-1:0];
                  w_state_nxt = ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               if (w_tmo) begin
                  w_state_nxt     = ST_IDLE;
                  w_frame_err_nxt = 1'b1;
               end else if (w_accept) begin
                  w_wr_data_nxt = bus.rx_p_data;
                  w_state_nxt   = ST_WR_EXEC;
               end
            end
            ST_WR_EXEC: begin
               w_wr_en_nxt = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_RD_ADDR: begin
               if (w_tmo) begin
                  w_state_nxt     = ST_IDLE;
                  w_frame_err_nxt = 1'b1;
               end else if (w_accept) begin
                  w_addr_nxt  = bus.rx_p_data[ADDR_WIDTH-1:0];
                  w_state_nxt = ST_RD_EXEC;
               end
            end
            ST_RD_EXEC: begin
               w_rd_en_nxt = 1'b1;
               if (bus.rf_rd_data_vld) begin
                  w_tx_data_nxt = bus.rf_rd_data;
                  w_state_nxt   = ST_TX_SEND;
               end else begin
                  w_state_nxt = ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               // Covers data returned in the same cycle as the visible rf_rd_en strobe.
               if (bus.rf_rd_data_vld) begin
                  w_tx_data_nxt = bus.rf_rd_data;
                  w_state_nxt   = ST_TX_SEND;
               end else if (w_tmo) begin
                  w_state_nxt     = ST_IDLE;
                  w_frame_err_nxt = 1'b1;
               end
            end
            ST_TX_SEND: begin
               if (!bus.tx_busy) begin
                  w_tx_vld_nxt = 1'b1;
                  w_state_nxt  = ST_IDLE;
               end else if (w_tmo) begin
                  w_state_nxt     = ST_IDLE;
                  w_frame_err_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_err_q      <= 1'b0;
         r_rf_addr    <= '0;
         r_rf_wr_data <= '0;
         r_tx_p_data  <= '0;
         r_rf_wr_en   <= 1'b0;
         r_rf_rd_en   <= 1'b0;
         r_tx_d_vld   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_ctrl_busy  <= 1'b0;
      end else begin
         r_err_q      <= w_err_lvl;
         r_rf_addr    <= w_addr_nxt;
         r_rf_wr_data <= w_wr_data_nxt;
         r_tx_p_data  <= w_tx_data_nxt;
         r_rf_wr_en   <= w_wr_en_nxt;
         r_rf_rd_en   <= w_rd_en_nxt;
         r_tx_d_vld   <= w_tx_vld_nxt;
         r_frame_err  <= w_frame_err_nxt;
         // Registered from the next state so it lines up with the state register.
         r_ctrl_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   assign bus.rf_addr    = r_rf_addr;
   assign bus.rf_wr_data = r_rf_wr_data;
   assign bus.tx_p_data  = r_tx_p_data;
   assign bus.rf_wr_en   = r_rf_wr_en;
   assign bus.rf_rd_en   = r_rf_rd_en;
   assign bus.tx_d_vld   = r_tx_d_vld;
   assign bus.frame_err  = r_frame_err;
   assign bus.ctrl_busy  = r_ctrl_busy;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Testbench for uart_rx_cmd_ctrl: table-driven frames plus hand sequences, scoreboarded strobes.
// Two instances: default timeout, and a 16-cycle timeout for the expiry case.
module tb_uart_rx_cmd_ctrl;
   import uart_rx_cmd_ctrl_pkg::*;

   localparam int K_WR  = 0;
   localparam int K_RD  = 1;
   localparam int K_ERR = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
   uart_rx_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

   uart_rx_cmd_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16'd4096),
      .CMD_WR(CMD_WR_OP), .CMD_RD(CMD_RD_OP)
   ) u_dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (if0)
   );

   uart_rx_cmd_ctrl #(
      .DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16'd16),
      .CMD_WR(CMD_WR_OP), .CMD_RD(CMD_RD_OP)
   ) u_dut_tmo (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (if1)
   );

   // Register-file read model for the main instance: data returns rd_lat cycles after rf_rd_en.
   logic [3:0] rd_pipe    = '0;
   int         rd_lat     = 0;
   logic       rd_resp_on = 1'b1;
   logic [7:0] rd_val     = 8'h00;
   always @(posedge clk) rd_pipe <= {rd_pipe[2:0], if0.rf_rd_en};
   assign if0.rf_rd_data_vld = rd_resp_on & ((rd_lat == 0) ? if0.rf_rd_en : rd_pipe[2'(rd_lat - 1)]);
   assign if0.rf_rd_data     = rd_val;
   assign if1.rf_rd_data_vld = 1'b0;
   assign if1.rf_rd_data     = 8'h00;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_exp_t;

   wr_exp_t    q_wr[$];
   logic [3:0] q_rd[$];
   logic [7:0] q_tx[$];
   int         q_err[$];
   int         q_err1[$];
   int         t_strobes = 0;

   typedef struct {
      int         nb;
      logic [7:0] b [3];
      int         rd_lat;
      logic [7:0] rd_dat;
      int         kind;
      logic [3:0] e_addr;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send0(input logic [7:0] b);
      @(negedge clk);
      if0.rx_p_data = b;
      if0.rx_d_vld  = 1'b1;
      @(negedge clk);
      if0.rx_d_vld  = 1'b0;
   endtask

   task automatic send1(input logic [7:0] b);
      @(negedge clk);
      if1.rx_p_data = b;
      if1.rx_d_vld  = 1'b1;
      @(negedge clk);
      if1.rx_d_vld  = 1'b0;
   endtask

   task automatic pending(input string nm);
      chk({nm, "_pending_wr"},  q_wr.size(),   0);
      chk({nm, "_pending_rd"},  q_rd.size(),   0);
      chk({nm, "_pending_tx"},  q_tx.size(),   0);
      chk({nm, "_pending_err"}, q_err.size(),  0);
      chk({nm, "_pending_err1"}, q_err1.size(), 0);
   endtask

   // Scoreboard: every observed strobe must match the oldest expectation of its kind.
   always @(negedge clk) begin : mon
      wr_exp_t e;
      if (rst_n) begin
         if (if0.rf_wr_en) begin
            chk("wr_strobe_expected", q_wr.size() > 0, 1);
            if (q_wr.size() > 0) begin
               e = q_wr.pop_front();
               chk("wr_addr", if0.rf_addr, e.addr);
               chk("wr_data", if0.rf_wr_data, e.data);
            end
         end
         if (if0.rf_rd_en) begin
            chk("rd_strobe_expected", q_rd.size() > 0, 1);
            if (q_rd.size() > 0) chk("rd_addr", if0.rf_addr, q_rd.pop_front());
         end
         if (if0.tx_d_vld) begin
            chk("tx_strobe_expected", q_tx.size() > 0, 1);
            if (q_tx.size() > 0) chk("tx_data", if0.tx_p_data, q_tx.pop_front());
         end
         if (if0.frame_err) begin
            chk("frame_err_expected", q_err.size() > 0, 1);
            if (q_err.size() > 0) void'(q_err.pop_front());
         end
         if (if1.frame_err) begin
            chk("t_frame_err_expected", q_err1.size() > 0, 1);
            if (q_err1.size() > 0) void'(q_err1.pop_front());
         end
         if (if1.rf_wr_en || if1.rf_rd_en || if1.tx_d_vld) t_strobes++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      int   cnt;

      tbl[0] = '{3, '{8'hAA, 8'h05, 8'h3C}, 0, 8'h00, K_WR,  4'h5, 8'h3C};
      tbl[1] = '{2, '{8'hBB, 8'h0A, 8'h00}, 2, 8'h5A, K_RD,  4'hA, 8'h5A};
      tbl[2] = '{1, '{8'h12, 8'h00, 8'h00}, 0, 8'h00, K_ERR, 4'h0, 8'h00};
      tbl[3] = '{3, '{8'hAA, 8'h1F, 8'h81}, 0, 8'h00, K_WR,  4'hF, 8'h81};
      tbl[4] = '{2, '{8'hBB, 8'h03, 8'h00}, 0, 8'hC3, K_RD,  4'h3, 8'hC3};
      tbl[5] = '{2, '{8'hBB, 8'h07, 8'h00}, 1, 8'h96, K_RD,  4'h7, 8'h96};
      tbl[6] = '{3, '{8'hAA, 8'h0E, 8'h00}, 0, 8'h00, K_WR,  4'hE, 8'h00};
      tbl[7] = '{1, '{8'h55, 8'h00, 8'h00}, 0, 8'h00, K_ERR, 4'h0, 8'h00};

      if0.rx_p_data = 8'h00; if0.rx_d_vld = 1'b0; if0.rx_par_err = 1'b0; if0.rx_stp_err = 1'b0;
      if0.tx_busy   = 1'b0;
      if1.rx_p_data = 8'h00; if1.rx_d_vld = 1'b0; if1.rx_par_err = 1'b0; if1.rx_stp_err = 1'b0;
      if1.tx_busy   = 1'b0;

      // Reset state
      #23;
      chk("reset_outputs", {if0.rf_wr_en, if0.rf_rd_en, if0.rf_addr, if0.rf_wr_data, if0.tx_p_data,
                            if0.tx_d_vld, if0.frame_err, if0.ctrl_busy}, 0);
      chk("reset_outputs_t", {if1.rf_wr_en, if1.rf_rd_en, if1.rf_addr, if1.rf_wr_data, if1.tx_p_data,
                              if1.tx_d_vld, if1.frame_err, if1.ctrl_busy}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      // Table-driven frames
      for (int i = 0; i < 8; i++) begin
         rd_lat = tbl[i].rd_lat;
         rd_val = tbl[i].rd_dat;
         case (tbl[i].kind)
            K_WR:    q_wr.push_back('{addr: tbl[i].e_addr, data: tbl[i].e_data});
            K_RD:    begin q_rd.push_back(tbl[i].e_addr); q_tx.push_back(tbl[i].e_data); end
            default: q_err.push_back(i);
         endcase
         for (int j = 0; j < tbl[i].nb; j++) begin
            send0(tbl[i].b[j]);
            if (j < tbl[i].nb - 1) begin
               chk($sformatf("vec%0d_busy_mid", i), if0.ctrl_busy, 1);
               idle(200);
            end
         end
         idle(20);
         chk($sformatf("vec%0d_busy_end", i), if0.ctrl_busy, 0);
         pending($sformatf("vec%0d", i));
      end
      chk("tx_data_hold", if0.tx_p_data, 8'h96);
      chk("addr_hold", if0.rf_addr, 4'hE);

      // Read held off by tx_busy; a BB arriving in TX_SEND is dropped
      rd_lat = 2; rd_val = 8'h5A; if0.tx_busy = 1'b1;
      q_rd.push_back(4'hA); q_tx.push_back(8'h5A);
      send0(8'hBB);
      send0(8'h0A);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) begin if0.rx_p_data = 8'hBB; if0.rx_d_vld = 1'b1; end
         if (i == 21) if0.rx_d_vld = 1'b0;
         @(negedge clk);
         if (if0.tx_d_vld) seen = 1'b1;
      end
      chk("tx_held_while_busy", seen, 0);
      chk("tx_send_busy", if0.ctrl_busy, 1);
      if0.tx_busy = 1'b0;
      @(negedge clk);
      chk("tx_vld_after_busy", if0.tx_d_vld, 1);
      chk("tx_data_5a", if0.tx_p_data, 8'h5A);
      @(negedge clk);
      chk("tx_vld_one_cycle", if0.tx_d_vld, 0);
      chk("tx_idle_busy", if0.ctrl_busy, 0);
      idle(5);
      pending("rd_busy");

      // Parity error edge in WR_ADDR aborts; flag held high in IDLE is ignored
      q_err.push_back(100);
      send0(8'hAA);
      idle(3);
      if0.rx_par_err = 1'b1;
      idle(6);
      chk("lerr_idle", if0.ctrl_busy, 0);
      if0.rx_par_err = 1'b0;
      idle(5);
      pending("lerr");
      q_wr.push_back('{addr: 4'h1, data: 8'hFF});
      send0(8'hAA); send0(8'h01); send0(8'hFF);
      idle(10);
      pending("lerr_recover");

      // Stop error on the same cycle as the data byte: error wins, byte is discarded
      q_err.push_back(101);
      send0(8'hAA); send0(8'h02);
      @(negedge clk);
      if0.rx_stp_err = 1'b1; if0.rx_p_data = 8'h77; if0.rx_d_vld = 1'b1;
      @(negedge clk);
      if0.rx_d_vld = 1'b0;
      idle(3);
      if0.rx_stp_err = 1'b0;
      idle(5);
      pending("simul_err");
      chk("simul_addr_latched", if0.rf_addr, 4'h2);
      chk("simul_data_unused", if0.rf_wr_data, 8'hFF);

      // Timeout on the 16-cycle instance: FRAME_ERR exactly 16 cycles after the accept
      q_err1.push_back(1);
      send1(8'hAA);
      chk("tmo_busy_start", if1.ctrl_busy, 1);
      seen = if1.frame_err;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (if1.frame_err) seen = 1'b1;
      end
      chk("tmo_not_early", seen, 0);
      @(negedge clk);
      chk("tmo_at_16", if1.frame_err, 1);
      chk("tmo_idle", if1.ctrl_busy, 0);
      idle(3);
      q_err1.push_back(2);
      send1(8'h05);
      idle(5);
      chk("tmo_after_busy", if1.ctrl_busy, 0);
      pending("tmo");
      chk("t_no_strobes", t_strobes, 0);

      // Reset asserted in RD_WAIT
      rd_resp_on = 1'b0;
      q_rd.push_back(4'h4);
      send0(8'hBB); send0(8'h04);
      idle(10);
      chk("rw_busy", if0.ctrl_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rw_reset_outputs", {if0.rf_wr_en, if0.rf_rd_en, if0.rf_addr, if0.rf_wr_data, if0.tx_p_data,
                               if0.tx_d_vld, if0.frame_err, if0.ctrl_busy}, 0);
      idle(3);
      rst_n = 1'b1;
      rd_resp_on = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         cnt += int'(if0.tx_d_vld) + int'(if0.frame_err);
      end
      chk("rw_no_tx_after_release", cnt, 0);
      chk("rw_idle", if0.ctrl_busy, 0);
      pending("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
